// File: rtl/adc_channel_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// adc_channel_sequencer_pkg
//   Shared types and constants for the joystick ADC channel sequencer.
//   adc_sample_t    : one 12-bit ADC conversion result
//   ADC_CENTRE      : mid-scale sample, the neutral joystick position
//   ADC_CH_W        : width of the ADC command/response channel field
//   adc_seq_state_t : sequencer FSM states
// ----------------------------------------------------------------------------
package adc_channel_sequencer_pkg;

    typedef logic [11:0] adc_sample_t;

    localparam adc_sample_t ADC_CENTRE = 12'h800;
    localparam int          ADC_CH_W   = 5;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,   // command presented to the ADC
        WAIT  = 2'd1,   // waiting for the matching response
        STORE = 2'd2    // captured sample written into its slot
    } adc_seq_state_t;

endpackage

// File: rtl/adc_channel_sequencer.sv
// ----------------------------------------------------------------------------
// adc_channel_sequencer
//   Drives the modular-ADC command/response streams, round-robining one
//   conversion at a time over NUM_CH channels. Keeps the latest sample per
//   slot and takes a frame-coherent snapshot on frame_tick so downstream
//   movement logic always reads a stable set of samples.
//
// Ports
//   clk          system clock (ADC clock-bridge output)
//   reset        synchronous, active-high
//   cmd_valid    command valid to the ADC
//   cmd_channel  ADC channel of the current command (FIRST_CH + slot)
//   cmd_ready    ADC accepts the command
//   rsp_valid    response valid from the ADC
//   rsp_channel  channel the response belongs to
//   rsp_data     12-bit conversion result
//   frame_tick   one-cycle pulse per video frame
//   live_data    latest sample per slot, slot k at [12k +: 12]
//   live_fresh   slot k written since the last frame_tick
//   snap_data    copy of live_data taken on frame_tick
//   snap_strobe  high the cycle snap_data shows a new snapshot
//   err_timeout  sticky: a response never arrived within TIMEOUT cycles
//   err_chan     sticky: a response carried the wrong channel
// ----------------------------------------------------------------------------
module adc_channel_sequencer
    import adc_channel_sequencer_pkg::*;
#(
    parameter int unsigned NUM_CH   = 2,    // 1..8
    parameter int unsigned FIRST_CH = 1,
    parameter int unsigned DISCARD  = 1,    // 0..3
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   cmd_valid,
    output logic [ADC_CH_W-1:0]    cmd_channel,
    input  logic                   cmd_ready,
    input  logic                   rsp_valid,
    input  logic [ADC_CH_W-1:0]    rsp_channel,
    input  logic [11:0]            rsp_data,
    input  logic                   frame_tick,
    output logic [NUM_CH*12-1:0]   live_data,
    output logic [NUM_CH-1:0]      live_fresh,
    output logic [NUM_CH*12-1:0]   snap_data,
    output logic                   snap_strobe,
    output logic                   err_timeout,
    output logic                   err_chan
);

    localparam int SLOT_W  = (NUM_CH > 1)  ? $clog2(NUM_CH)      : 1;
    localparam int TIMER_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    // With a single channel the mux never switches, so nothing needs settling.
    localparam logic [1:0] DISCARD_RELOAD = (NUM_CH > 1) ? 2'(DISCARD) : 2'd0;
    localparam logic [SLOT_W-1:0]  LAST_SLOT   = SLOT_W'(NUM_CH - 1);
    localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT);

    adc_seq_state_t      state;
    adc_seq_state_t      state_next;
    logic [SLOT_W-1:0]   slot;
    logic [TIMER_W-1:0]  timer;
    logic [1:0]          discard_cnt;
    adc_sample_t         cap_data;
    logic [ADC_CH_W-1:0] issued_channel;

    // Per-cycle actions decoded by the FSM.
    logic capture_en;
    logic store_en;
    logic discard_hit;
    logic chan_err_hit;
    logic timeout_hit;

    // The slot does not move between ISSUE and STORE, so the channel a
    // response must match is simply the one currently being commanded.
    assign issued_channel = ADC_CH_W'(FIRST_CH) + ADC_CH_W'(slot);
    assign cmd_channel    = issued_channel;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ISSUE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and action decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned and infers a latch.
        state_next   = state;
        cmd_valid    = 1'b0;
        capture_en   = 1'b0;
        store_en     = 1'b0;
        discard_hit  = 1'b0;
        chan_err_hit = 1'b0;
        timeout_hit  = 1'b0;

        unique case (state)
            ISSUE: begin
                // Held low while reset is asserted so no command leaks out
                // of a sequencer that is being cleared.
                cmd_valid = ~reset;
                if (cmd_ready) begin
                    state_next = WAIT;
                end
            end

            WAIT: begin
                if (rsp_valid) begin
                    if (rsp_channel != issued_channel) begin
                        chan_err_hit = 1'b1;
                        state_next   = ISSUE;
                    end else if (discard_cnt != 2'd0) begin
                        // Mux still settling after a channel switch.
                        discard_hit = 1'b1;
                        state_next  = ISSUE;
                    end else begin
                        capture_en = 1'b1;
                        state_next = STORE;
                    end
                end else if (timer == TIMER_LIMIT) begin
                    timeout_hit = 1'b1;
                    state_next  = ISSUE;
                end
            end

            STORE: begin
                store_en   = 1'b1;
                state_next = ISSUE;
            end

            default: begin
                state_next = ISSUE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer datapath: slot pointer, response timer, settle counter,
    // capture register, sticky errors, snapshot strobe.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            slot        <= '0;
            timer       <= '0;
            discard_cnt <= 2'(DISCARD);
            cap_data    <= ADC_CENTRE;
            err_timeout <= 1'b0;
            err_chan    <= 1'b0;
            snap_strobe <= 1'b0;
        end else begin
            snap_strobe <= frame_tick;

            // Timer runs only in WAIT and is zero on entry.
            if (state == WAIT) begin
                timer <= timer + TIMER_W'(1);
            end else begin
                timer <= '0;
            end

            if (capture_en) begin
                cap_data <= rsp_data;
            end

            if (discard_hit) begin
                discard_cnt <= discard_cnt - 2'd1;
            end

            if (store_en) begin
                slot        <= (slot == LAST_SLOT) ? '0 : slot + SLOT_W'(1);
                discard_cnt <= DISCARD_RELOAD;
            end

            if (chan_err_hit) begin
                err_chan <= 1'b1;
            end

            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Slot bank: one live sample, one snapshot and one fresh flag per slot.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        adc_sample_t live_q;
        adc_sample_t snap_q;
        logic        fresh_q;

        always_ff @(posedge clk) begin
            // NOTE: the sample registers are reset on purpose: consumers must
            // see a centred joystick, not stale or X data, right after reset.
            if (reset) begin
                live_q  <= ADC_CENTRE;
                snap_q  <= ADC_CENTRE;
                fresh_q <= 1'b0;
            end else begin
                if (frame_tick) begin
                    snap_q  <= live_q;
                    fresh_q <= 1'b0;
                end
                // NOTE: non-blocking assignments make the snapshot above read
                // the pre-store sample, and this later assignment wins, so a
                // store coinciding with frame_tick still leaves fresh set.
                if (store_en && (slot == SLOT_W'(k))) begin
                    live_q  <= cap_data;
                    fresh_q <= 1'b1;
                end
            end
        end

        assign live_data[k*12 +: 12] = live_q;
        assign snap_data[k*12 +: 12] = snap_q;
        assign live_fresh[k]         = fresh_q;
    end

endmodule

// File: tb/tb_adc_channel_sequencer.sv
// ----------------------------------------------------------------------------
// tb_adc_channel_sequencer
//   Directed bench for adc_channel_sequencer (NUM_CH=2, FIRST_CH=1,
//   DISCARD=1, TIMEOUT=255). A small ADC model accepts every command and
//   answers two cycles after the handshake; it can also stay silent or answer
//   with the wrong channel. All inputs change 1 ns after a rising edge and
//   all outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_adc_channel_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [4:0]  cmd_channel;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [4:0]  rsp_channel;
    logic [11:0] rsp_data;
    logic        frame_tick;
    logic [23:0] live_data;
    logic [1:0]  live_fresh;
    logic [23:0] snap_data;
    logic        snap_strobe;
    logic        err_timeout;
    logic        err_chan;

    int tests_run    = 0;
    int tests_failed = 0;

    // ADC model state. model_mode: 0 normal, 1 silent, 2 wrong channel.
    int          model_mode;
    int          pend_cnt;
    logic [4:0]  pend_ch;
    logic [11:0] ch_data [0:31];
    int          log_q[$];

    always #5 clk = ~clk;

    adc_channel_sequencer #(
        .NUM_CH   (2),
        .FIRST_CH (1),
        .DISCARD  (1),
        .TIMEOUT  (255)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_channel (cmd_channel),
        .cmd_ready   (cmd_ready),
        .rsp_valid   (rsp_valid),
        .rsp_channel (rsp_channel),
        .rsp_data    (rsp_data),
        .frame_tick  (frame_tick),
        .live_data   (live_data),
        .live_fresh  (live_fresh),
        .snap_data   (snap_data),
        .snap_strobe (snap_strobe),
        .err_timeout (err_timeout),
        .err_chan    (err_chan)
    );

    // ---------------- ADC model ----------------
    task automatic model_rsp();
        rsp_valid = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0 && model_mode != 1) begin
                rsp_valid   = 1'b1;
                rsp_channel = (model_mode == 2) ? ((pend_ch == 5'd1) ? 5'd2 : 5'd1) : pend_ch;
                rsp_data    = ch_data[pend_ch];
            end
        end
    endtask

    // A command visible now is accepted at the coming edge; answer two
    // cycles after that edge.
    task automatic model_cmd();
        if (cmd_valid && cmd_ready) begin
            pend_cnt = 2;
            pend_ch  = cmd_channel;
            log_q.push_back(int'(cmd_channel));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_rsp();
        model_cmd();
    endtask

    task automatic wait_log(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget; i++) begin
            if (log_q.size() >= n) break;
            step();
        end
        ok = (log_q.size() >= n);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset      = 1'b1;
        frame_tick = 1'b0;
        rsp_valid  = 1'b0;
        pend_cnt   = 0;
        model_mode = 0;
        log_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        model_cmd();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (cmd_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid); end
        tests_run++;
        if (live_data !== 24'h800800) begin tests_failed++; $display("FAIL reset_live: got %h want 800800", live_data); end
        tests_run++;
        if (snap_data !== 24'h800800) begin tests_failed++; $display("FAIL reset_snap: got %h want 800800", snap_data); end
        tests_run++;
        if ({live_fresh, snap_strobe, err_timeout, err_chan} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got fresh=%b strobe=%b to=%b ch=%b want all 0", live_fresh, snap_strobe, err_timeout, err_chan);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (cmd_valid !== 1'b1 || cmd_channel !== 5'd1) begin
            tests_failed++;
            $display("FAIL reset_first_issue: got valid=%b ch=%0d want valid=1 ch=1", cmd_valid, cmd_channel);
        end
        model_cmd();
    endtask

    task automatic test_sequence();
        int exp_ch [5] = '{1, 1, 2, 2, 1};
        bit ok;
        do_reset();
        ch_data[1] = 12'h111;
        ch_data[2] = 12'h222;
        wait_log(2, 50, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL seq_wait2: got %0d commands want 2", log_q.size()); end
        // First ch1 response was dropped for settling.
        tests_run++;
        if (live_data !== 24'h800800 || live_fresh !== 2'b00) begin
            tests_failed++;
            $display("FAIL seq_discard: got live=%h fresh=%b want 800800 00", live_data, live_fresh);
        end
        wait_log(5, 100, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL seq_wait5: got %0d commands want 5", log_q.size()); end
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (log_q[i] !== exp_ch[i]) begin
                tests_failed++;
                $display("FAIL seq_channel[%0d]: got %0d want %0d", i, log_q[i], exp_ch[i]);
            end
        end
        tests_run++;
        if (live_data !== 24'h222111 || live_fresh !== 2'b11) begin
            tests_failed++;
            $display("FAIL seq_store: got live=%h fresh=%b want 222111 11", live_data, live_fresh);
        end
    endtask

    // Continues from test_sequence without reset.
    task automatic test_snapshot();
        bit ok;
        ch_data[1] = 12'd2500;
        ch_data[2] = 12'd600;
        wait_log(9, 100, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL snap_wait: got %0d commands want 9", log_q.size()); end
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        tests_run++;
        if (snap_data !== {12'd600, 12'd2500}) begin
            tests_failed++;
            $display("FAIL snap_data: got %h want %h", snap_data, {12'd600, 12'd2500});
        end
        tests_run++;
        if (snap_strobe !== 1'b1) begin tests_failed++; $display("FAIL snap_strobe_high: got %b want 1", snap_strobe); end
        tests_run++;
        if (live_fresh !== 2'b00) begin tests_failed++; $display("FAIL snap_fresh_clear: got %b want 00", live_fresh); end
        step();
        tests_run++;
        if (snap_strobe !== 1'b0) begin tests_failed++; $display("FAIL snap_strobe_low: got %b want 0", snap_strobe); end
    endtask

    task automatic test_timeout();
        int n = 0;
        do_reset();
        model_mode = 1;
        // Handshake edge plus 256 WAIT cycles before the timeout lands.
        while (err_timeout !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        tests_run++;
        if (n != 257) begin tests_failed++; $display("FAIL timeout_cycles: got %0d want 257", n); end
        tests_run++;
        if (log_q.size() != 2 || log_q[1] != 1) begin
            tests_failed++;
            $display("FAIL timeout_reissue: got %0d commands last ch %0d want 2 and ch 1", log_q.size(), log_q[log_q.size()-1]);
        end
        repeat (3) step();
        tests_run++;
        if (err_timeout !== 1'b1 || err_chan !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_sticky: got to=%b ch=%b want 1 0", err_timeout, err_chan);
        end
    endtask

    task automatic test_wrong_channel();
        bit ok;
        do_reset();
        model_mode = 2;
        wait_log(2, 20, ok);
        tests_run++;
        if (!ok || log_q[1] != 1) begin tests_failed++; $display("FAIL chan_reissue: got %0d commands want 2 on ch 1", log_q.size()); end
        tests_run++;
        if (err_chan !== 1'b1 || err_timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL chan_err: got ch=%b to=%b want 1 0", err_chan, err_timeout);
        end
        tests_run++;
        if (live_data !== 24'h800800 || live_fresh !== 2'b00) begin
            tests_failed++;
            $display("FAIL chan_live: got live=%h fresh=%b want 800800 00", live_data, live_fresh);
        end
    endtask

    task automatic test_tick_on_store();
        bit ok;
        do_reset();
        ch_data[1] = 12'h123;
        ch_data[2] = 12'h456;
        wait_log(6, 100, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL coinc_wait: got %0d commands want 6", log_q.size()); end
        ch_data[1] = 12'd3000;
        // Response goes out two steps on, is captured next edge, and the
        // STORE edge follows: raise frame_tick for that edge.
        step();
        step();
        step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        tests_run++;
        if (snap_data !== 24'h456123) begin tests_failed++; $display("FAIL coinc_snap: got %h want 456123", snap_data); end
        tests_run++;
        if (live_data !== {12'h456, 12'd3000}) begin
            tests_failed++;
            $display("FAIL coinc_live: got %h want %h", live_data, {12'h456, 12'd3000});
        end
        tests_run++;
        if (live_fresh !== 2'b01) begin tests_failed++; $display("FAIL coinc_fresh: got %b want 01", live_fresh); end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        do_reset();
        ch_data[1] = 12'h321;
        ch_data[2] = 12'h654;
        step();
        reset = 1'b1;
        step();
        // rsp_valid is now raised for the first edge after reset.
        tests_run++;
        if (cmd_valid !== 1'b0 || live_data !== 24'h800800 || snap_data !== 24'h800800) begin
            tests_failed++;
            $display("FAIL rstw_outputs: got valid=%b live=%h snap=%h want 0 800800 800800", cmd_valid, live_data, snap_data);
        end
        tests_run++;
        if ({live_fresh, snap_strobe, err_timeout, err_chan} !== 5'b0) begin
            tests_failed++;
            $display("FAIL rstw_flags: got fresh=%b strobe=%b to=%b ch=%b want all 0", live_fresh, snap_strobe, err_timeout, err_chan);
        end
        log_q.delete();
        reset = 1'b0;
        #1;
        model_cmd();
        wait_log(2, 40, ok);
        tests_run++;
        if (!ok || log_q[0] != 1 || log_q[1] != 1) begin
            tests_failed++;
            $display("FAIL rstw_resume: got %0d commands ch %0d,%0d want 1,1", log_q.size(), log_q[0], log_q[1]);
        end
        tests_run++;
        if (live_data !== 24'h800800 || live_fresh !== 2'b00 || err_chan !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstw_ignored: got live=%h fresh=%b ch=%b want 800800 00 0", live_data, live_fresh, err_chan);
        end
        wait_log(3, 40, ok);
        tests_run++;
        if (!ok || log_q[2] != 2 || live_data !== 24'h800321) begin
            tests_failed++;
            $display("FAIL rstw_store: got %0d commands live=%h want ch 2 live 800321", log_q.size(), live_data);
        end
    endtask

    initial begin
        reset       = 1'b1;
        cmd_ready   = 1'b1;
        rsp_valid   = 1'b0;
        rsp_channel = 5'd0;
        rsp_data    = 12'd0;
        frame_tick  = 1'b0;
        model_mode  = 0;
        pend_cnt    = 0;
        pend_ch     = 5'd0;
        for (int i = 0; i < 32; i++) ch_data[i] = 12'd0;

        test_reset();
        test_sequence();
        test_snapshot();
        test_timeout();
        test_wrong_channel();
        test_tick_on_store();
        test_reset_mid_wait();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
